// File: rtl/ofdm_map_pkg.sv
// ofdm_map_pkg: shared map codes, bandwidth limit and pilot PRBS definitions.
package ofdm_map_pkg;
  typedef enum logic [1:0] {
    MAP_NULL  = 2'd0,
    MAP_DATA  = 2'd1,
    MAP_PILOT = 2'd2,
    MAP_RSVD  = 2'd3
  } map_code_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
  localparam int NUM_BW = 6;
  localparam int PRBS_W = 11;
  localparam int PRBS_TAP_A = 10;
  localparam int PRBS_TAP_B = 8;
  // Fibonacci step for x^11 + x^9 + 1, shifting towards the MSB
  function automatic logic [PRBS_W-1:0] prbs_next(input logic [PRBS_W-1:0] s);
    return {s[PRBS_W-2:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
  endfunction
endpackage

// File: rtl/ofdm_subcarrier_mapper_pilot_prbs.sv
// pilot_prbs: 11-bit pilot LFSR with seed load and step enable; MSB is the BPSK sign.
module pilot_prbs import ofdm_map_pkg::*; #(
  parameter logic [PRBS_W-1:0] SEED = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic step,
  output logic sign
);
  logic [PRBS_W-1:0] lfsr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr <= SEED;
    else if (load) lfsr <= SEED;
    else if (step) lfsr <= prbs_next(lfsr);
  assign sign = lfsr[PRBS_W-1];
endmodule

// File: rtl/ofdm_subcarrier_mapper.sv
// ofdm_subcarrier_mapper: scans FFT bins against the map ROM and emits data, pilot or null I/Q samples.
module ofdm_subcarrier_mapper import ofdm_map_pkg::*; #(
  parameter int DEPTH_RAM = 10,
  parameter int FFTSIZE = 1024,
  parameter int DW = 16,
  parameter logic signed [DW-1:0] PILOT_AMP = 16'sd11585,
  parameter logic [PRBS_W-1:0] PRBS_SEED = 11'h7FF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [2:0]             bw_sel,
  output logic [DEPTH_RAM-1:0]   map_addr,
  output logic [2:0]             map_index_bw,
  input  logic [1:0]             map_code,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [DW-1:0]   s_i,
  input  logic signed [DW-1:0]   s_q,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic signed [DW-1:0]   m_i,
  output logic signed [DW-1:0]   m_q,
  output logic                   m_sop,
  output logic                   m_eop,
  output logic                   busy,
  output logic                   bw_err,
  output logic [DEPTH_RAM:0]     data_cnt
);
  state_t state;
  map_code_t code;
  logic [DEPTH_RAM-1:0] bin_cnt;
  logic run, adv, last, accept, pilot_neg;
  assign code = map_code_t'(map_code);
  assign run = state == ST_RUN;
  assign adv = run && (!m_valid || m_ready) && (code != MAP_DATA || s_valid);
  assign s_ready = adv && code == MAP_DATA;
  // Address runs one bin ahead on advance so the registered ROM code always matches bin_cnt
  assign map_addr = run ? (adv ? bin_cnt + 1'b1 : bin_cnt) : '0;
  assign last = bin_cnt == DEPTH_RAM'(FFTSIZE - 1);
  assign accept = state == ST_IDLE && start && bw_sel < 3'(NUM_BW);
  pilot_prbs #(.SEED(PRBS_SEED)) u_prbs (
    .clk(clk), .rst_n(rst_n), .load(accept),
    .step(adv && code == MAP_PILOT), .sign(pilot_neg)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      bin_cnt <= '0;
      map_index_bw <= '0;
      m_valid <= 1'b0;
      m_i <= '0;
      m_q <= '0;
      m_sop <= 1'b0;
      m_eop <= 1'b0;
      busy <= 1'b0;
      bw_err <= 1'b0;
      data_cnt <= '0;
    end else begin
      if (adv) begin
        m_valid <= 1'b1;
        m_sop <= bin_cnt == '0;
        m_eop <= last;
        m_i <= code == MAP_DATA ? s_i : code == MAP_PILOT ? (pilot_neg ? -PILOT_AMP : PILOT_AMP) : '0;
        m_q <= code == MAP_DATA ? s_q : '0;
        if (code == MAP_DATA) data_cnt <= data_cnt + 1'b1;
        if (last) state <= ST_DRAIN;
        else bin_cnt <= bin_cnt + 1'b1;
      end else if (m_ready) m_valid <= 1'b0;
      if (accept) begin
        state <= ST_RUN;
        map_index_bw <= bw_sel;
        bin_cnt <= '0;
        data_cnt <= '0;
        busy <= 1'b1;
      end
      if (state == ST_IDLE && start && !accept) bw_err <= 1'b1;
      if (state == ST_DRAIN && (!m_valid || m_ready)) begin
        state <= ST_IDLE;
        bin_cnt <= '0;
        busy <= 1'b0;
      end
    end
endmodule

// File: tb/tb_ofdm_subcarrier_mapper.sv
// tb_ofdm_subcarrier_mapper: directed scenario tests with a registered map ROM and a bin-order reference model.
module tb_ofdm_subcarrier_mapper;
  localparam int N = 1024;
  logic clk = 0, rst_n = 0, start = 0, s_valid = 0, m_ready = 0;
  logic [2:0] bw_sel = 0, map_index_bw;
  logic [9:0] map_addr;
  logic [1:0] map_code;
  logic s_ready, m_valid, m_sop, m_eop, busy, bw_err;
  logic signed [15:0] s_i = 0, s_q = 0, m_i, m_q;
  logic [10:0] data_cnt;
  logic [1:0] rom [N];
  logic signed [15:0] got_i [N], got_q [N], exp_i [N], exp_q [N];
  logic got_sop [N], got_eop [N];
  int tests = 0, fails = 0;
  int n_out, k_src, stab_err, sready_err, last_cyc, exp_data;
  bit timeout, busy_after;

  ofdm_subcarrier_mapper dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bw_sel(bw_sel), .map_addr(map_addr),
    .map_index_bw(map_index_bw), .map_code(map_code), .s_valid(s_valid), .s_ready(s_ready),
    .s_i(s_i), .s_q(s_q), .m_valid(m_valid), .m_ready(m_ready), .m_i(m_i), .m_q(m_q),
    .m_sop(m_sop), .m_eop(m_eop), .busy(busy), .bw_err(bw_err), .data_cnt(data_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) map_code <= rom[map_addr];

  function automatic logic signed [15:0] src_i(input int k);
    return 16'(k * 7 + 3);
  endfunction
  function automatic logic signed [15:0] src_q(input int k);
    return 16'(-k * 5 - 1);
  endfunction

  task automatic fill_data();
    for (int b = 0; b < N; b++) rom[b] = 2'd1;
  endtask

  task automatic fill_pilot();
    for (int b = 0; b < N; b++) rom[b] = (b % 12 == 0) ? 2'd2 : 2'd1;
    for (int b = 500; b <= 523; b++) rom[b] = 2'd0;
    rom[1022] = 2'd3;
  endtask

  task automatic build_expected();
    logic [10:0] prbs;
    int d;
    prbs = 11'h7FF;
    d = 0;
    for (int b = 0; b < N; b++) begin
      exp_i[b] = 0;
      exp_q[b] = 0;
      if (rom[b] == 2'd1) begin
        exp_i[b] = src_i(d);
        exp_q[b] = src_q(d);
        d++;
      end else if (rom[b] == 2'd2) begin
        exp_i[b] = prbs[10] ? -16'sd11585 : 16'sd11585;
        prbs = {prbs[9:0], prbs[10] ^ prbs[8]};
      end
    end
    exp_data = d;
  endtask

  task automatic run_sym(input int rdy_pct, input int vld_pct, input logic [2:0] bw,
                         input int abort_at, input bit extra_start);
    int cyc;
    bit hold, done;
    logic signed [15:0] hi, hq;
    logic hs, he;
    n_out = 0; k_src = 0; stab_err = 0; sready_err = 0; timeout = 0;
    hold = 0; done = 0; cyc = 0; hi = 0; hq = 0; hs = 0; he = 0;
    @(negedge clk);
    start = 1; bw_sel = bw;
    @(negedge clk);
    start = 0;
    while (!done) begin
      m_ready = $urandom_range(99) < rdy_pct;
      s_valid = $urandom_range(99) < vld_pct;
      s_i = src_i(k_src);
      s_q = src_q(k_src);
      if (extra_start && cyc == 100) start = 1;
      #1;
      if (hold && (!m_valid || m_i !== hi || m_q !== hq || m_sop !== hs || m_eop !== he)) stab_err++;
      hold = m_valid && !m_ready;
      hi = m_i; hq = m_q; hs = m_sop; he = m_eop;
      if (s_ready && map_code != 2'd1) sready_err++;
      if (s_valid && s_ready) k_src++;
      if (m_valid && m_ready) begin
        if (n_out < N) begin
          got_i[n_out] = m_i; got_q[n_out] = m_q;
          got_sop[n_out] = m_sop; got_eop[n_out] = m_eop;
        end
        n_out++;
        if (m_eop) begin
          done = 1;
          if (extra_start) start = 1;
        end
      end
      if (abort_at > 0 && n_out == abort_at) done = 1;
      cyc++;
      if (cyc > 20000) begin
        timeout = 1;
        done = 1;
      end
      @(negedge clk);
      start = 0;
    end
    last_cyc = cyc;
    busy_after = busy;
  endtask

  task automatic check_symbol(input string name);
    int errs, first;
    errs = 0; first = -1;
    tests++;
    if (timeout || n_out !== N) begin
      fails++;
      $display("FAIL %s count: got %0d outputs (timeout=%0d), expected %0d", name, n_out, timeout, N);
    end
    for (int b = 0; b < N && b < n_out; b++)
      if (got_i[b] !== exp_i[b] || got_q[b] !== exp_q[b] || got_sop[b] !== (b == 0) || got_eop[b] !== (b == N - 1)) begin
        if (first < 0) first = b;
        errs++;
      end
    tests++;
    if (errs != 0) begin
      fails++;
      $display("FAIL %s seq: %0d bad bins, first bin %0d got i=%0d q=%0d sop=%0b eop=%0b expected i=%0d q=%0d",
               name, errs, first, got_i[first], got_q[first], got_sop[first], got_eop[first], exp_i[first], exp_q[first]);
    end
    tests++;
    if (data_cnt !== 11'(exp_data)) begin
      fails++;
      $display("FAIL %s data_cnt: got %0d expected %0d", name, data_cnt, exp_data);
    end
    tests++;
    if (busy_after !== 1'b0) begin
      fails++;
      $display("FAIL %s busy_after_eop: got %0b expected 0", name, busy_after);
    end
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if ({m_valid, m_sop, m_eop, busy, bw_err, s_ready} !== 6'b0 || m_i !== 16'sd0 || m_q !== 16'sd0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%0b sop=%0b eop=%0b busy=%0b err=%0b sr=%0b i=%0d q=%0d expected all 0",
               m_valid, m_sop, m_eop, busy, bw_err, s_ready, m_i, m_q);
    end
    tests++;
    if (data_cnt !== 11'd0 || map_addr !== 10'd0 || map_index_bw !== 3'd0) begin
      fails++;
      $display("FAIL reset_regs: got data_cnt=%0d addr=%0d bw=%0d expected 0", data_cnt, map_addr, map_index_bw);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_all_data();
    fill_data();
    build_expected();
    run_sym(100, 100, 3'd0, 0, 0);
    check_symbol("all_data");
    tests++;
    if (last_cyc !== N + 1) begin
      fails++;
      $display("FAIL all_data throughput: got %0d cycles expected %0d", last_cyc, N + 1);
    end
    tests++;
    if (sready_err !== 0 || map_index_bw !== 3'd0) begin
      fails++;
      $display("FAIL all_data misc: got sready_err=%0d bw=%0d expected 0 0", sready_err, map_index_bw);
    end
  endtask

  task automatic test_pilots();
    fill_pilot();
    build_expected();
    run_sym(100, 100, 3'd1, 0, 0);
    check_symbol("pilots");
    tests++;
    if (got_i[0] !== -16'sd11585 || got_q[0] !== 16'sd0 || got_i[12] !== -16'sd11585) begin
      fails++;
      $display("FAIL pilots first: got i0=%0d q0=%0d i12=%0d expected -11585 0 -11585", got_i[0], got_q[0], got_i[12]);
    end
    tests++;
    if (got_i[500] !== 16'sd0 || got_q[523] !== 16'sd0 || got_i[1022] !== 16'sd0 || exp_data !== 915) begin
      fails++;
      $display("FAIL pilots nulls: got i500=%0d q523=%0d i1022=%0d data=%0d expected 0 0 0 915",
               got_i[500], got_q[523], got_i[1022], exp_data);
    end
  endtask

  task automatic test_stalls();
    fill_pilot();
    build_expected();
    run_sym(50, 60, 3'd5, 0, 0);
    check_symbol("stalls");
    tests++;
    if (stab_err !== 0 || sready_err !== 0) begin
      fails++;
      $display("FAIL stalls handshake: got stab_err=%0d sready_err=%0d expected 0 0", stab_err, sready_err);
    end
    tests++;
    if (k_src !== exp_data) begin
      fails++;
      $display("FAIL stalls consumed: got %0d expected %0d", k_src, exp_data);
    end
  endtask

  task automatic test_bw_err();
    int seen;
    seen = 0;
    @(negedge clk);
    start = 1; bw_sel = 3'd6; m_ready = 1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_valid || busy) seen++;
    end
    tests++;
    if (bw_err !== 1'b1 || seen !== 0) begin
      fails++;
      $display("FAIL bw_err set: got bw_err=%0b active_cycles=%0d expected 1 0", bw_err, seen);
    end
    fill_data();
    build_expected();
    run_sym(100, 100, 3'd2, 0, 0);
    check_symbol("bw_retry");
    tests++;
    if (map_index_bw !== 3'd2 || bw_err !== 1'b1) begin
      fails++;
      $display("FAIL bw_retry regs: got bw=%0d bw_err=%0b expected 2 1", map_index_bw, bw_err);
    end
  endtask

  task automatic test_reset_mid();
    fill_pilot();
    build_expected();
    run_sym(100, 100, 3'd3, 300, 0);
    #2;
    rst_n = 0;
    #1;
    tests++;
    if ({m_valid, m_sop, m_eop, busy, bw_err, s_ready} !== 6'b0 || m_i !== 16'sd0 || m_q !== 16'sd0 || data_cnt !== 11'd0) begin
      fails++;
      $display("FAIL reset_mid async: got v=%0b busy=%0b err=%0b i=%0d q=%0d data_cnt=%0d expected all 0",
               m_valid, busy, bw_err, m_i, m_q, data_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    run_sym(70, 80, 3'd4, 0, 0);
    check_symbol("after_reset");
  endtask

  task automatic test_back_to_back();
    int extra;
    extra = 0;
    fill_pilot();
    build_expected();
    run_sym(100, 100, 3'd1, 0, 1);
    check_symbol("start_ignored");
    m_ready = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (m_valid || busy) extra++;
    end
    tests++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL start_ignored extra: got %0d active cycles expected 0", extra);
    end
  endtask

  initial begin
    for (int b = 0; b < N; b++) rom[b] = 2'd0;
    test_reset();
    test_all_data();
    test_pilots();
    test_stalls();
    test_bw_err();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
